// File: rtl/seq_subtractor_64.sv
// -----------------------------------------------------------------------------
// seq_subtractor_64
//
// Bit-serial-by-byte 64-bit subtractor. An accepted start latches A, B and
// Bin. The block then processes one 8-bit slice per clock, least significant
// slice first, and pulses done for one cycle when diff and Bout are valid.
//
// Optional feature: define SEQ_SUB_OVERFLOW_EN to add the signed-overflow
// output V. V is registered alongside Bout.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   begin an operation (sampled only in IDLE)
//   A      in  64   minuend (latched on the accepting edge)
//   B      in  64   subtrahend (latched on the accepting edge)
//   Bin    in   1   borrow-in (latched on the accepting edge)
//   diff   out 64   (A - B - Bin) mod 2^64, built slice by slice
//   Bout   out  1   1 iff unsigned A < B + Bin
//   busy   out  1   high while slices are being processed
//   done   out  1   one-cycle pulse when diff/Bout are valid
//   V      out  1   signed overflow (only with SEQ_SUB_OVERFLOW_EN)
// -----------------------------------------------------------------------------
module seq_subtractor_64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Bin,
  output logic [63:0] diff,
  output logic        Bout,
  output logic        busy,
  output logic        done
`ifdef SEQ_SUB_OVERFLOW_EN
  ,
  output logic        V
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [63:0] diff_q, diff_d;
  logic [2:0]  k_q, k_d;
  logic        borrow_q, borrow_d;
  logic        bout_q, bout_d;
`ifdef SEQ_SUB_OVERFLOW_EN
  logic        v_q, v_d;
`endif

  // Current slice operands and the 9-bit slice result; bit 8 is the borrow out
  // of the slice because a negative result wraps into the top bit.
  logic [7:0] slice_a, slice_b;
  logic [8:0] slice_res;

  assign slice_a   = a_q[{k_q, 3'b000} +: 8];
  assign slice_b   = b_q[{k_q, 3'b000} +: 8];
  assign slice_res = {1'b0, slice_a} - {1'b0, slice_b} - {8'b0, borrow_q};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in a combinational block gets a default at
  // the top so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: if (k_q == 3'd7) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == ST_CALC);
    done = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    k_d      = k_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
`ifdef SEQ_SUB_OVERFLOW_EN
    v_d      = v_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          k_d      = 3'd0;
        end
      end
      ST_CALC: begin
        diff_d[{k_q, 3'b000} +: 8] = slice_res[7:0];
        borrow_d = slice_res[8];
        k_d      = k_q + 3'd1;  // wraps back to 0 after slice 7
        if (k_q == 3'd7) begin
          bout_d = slice_res[8];
`ifdef SEQ_SUB_OVERFLOW_EN
          // slice_res[7] is the final diff[63] being written on this edge.
          v_d = (a_q[63] != b_q[63]) && (slice_res[7] != a_q[63]);
`endif
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      k_q      <= 3'd0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
`ifdef SEQ_SUB_OVERFLOW_EN
      v_q      <= 1'b0;
`endif
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      k_q      <= k_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
`ifdef SEQ_SUB_OVERFLOW_EN
      v_q      <= v_d;
`endif
    end
  end

  assign diff = diff_q;
  assign Bout = bout_q;
`ifdef SEQ_SUB_OVERFLOW_EN
  assign V    = v_q;
`endif

endmodule

// File: tb/tb_seq_subtractor_64.sv
// -----------------------------------------------------------------------------
// tb_seq_subtractor_64
//
// Directed self-checking bench for seq_subtractor_64. Inputs are driven on the
// falling edge and outputs are sampled on the falling edge, half a period away
// from the active rising edge. Define SEQ_SUB_OVERFLOW_EN to also check V.
// -----------------------------------------------------------------------------
module tb_seq_subtractor_64;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
  logic        Bin;
  logic [63:0] diff;
  logic        Bout;
  logic        busy;
  logic        done;
`ifdef SEQ_SUB_OVERFLOW_EN
  logic        V;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  seq_subtractor_64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .diff  (diff),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
`ifdef SEQ_SUB_OVERFLOW_EN
    ,
    .V     (V)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " diff"}, diff, 64'd0);
    check({tag, " Bout"}, {63'd0, Bout}, 64'd0);
    check({tag, " busy"}, {63'd0, busy}, 64'd0);
    check({tag, " done"}, {63'd0, done}, 64'd0);
`ifdef SEQ_SUB_OVERFLOW_EN
    check({tag, " V"}, {63'd0, V}, 64'd0);
`endif
  endtask

  // One full operation. hold keeps start high throughout CALC to show it is
  // ignored; operands are scrambled right after acceptance.
  task automatic run_op(input string tag, input logic [63:0] a,
                        input logic [63:0] b, input logic bin, input logic hold,
                        input logic [63:0] exp_diff, input logic exp_bout,
                        input logic exp_v);
    int n;
    int busy_cnt;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk);  // accepting edge
    @(negedge clk);
    if (!hold) start = 1'b0;
    A = ~a; B = a ^ 64'hA5A5_5A5A_0F0F_F0F0; Bin = ~bin;
    n = 0;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'd8);
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'd8);
    check({tag, " busy at done"}, {63'd0, busy}, 64'd0);
    check({tag, " diff"}, diff, exp_diff);
    check({tag, " Bout"}, {63'd0, Bout}, {63'd0, exp_bout});
`ifdef SEQ_SUB_OVERFLOW_EN
    check({tag, " V"}, {63'd0, V}, {63'd0, exp_v});
`else
    if (exp_v) begin end  // V only observable with the overflow option
`endif
    @(negedge clk);
    check({tag, " done pulse width"}, {63'd0, done}, 64'd0);
    check({tag, " diff held"}, diff, exp_diff);
    check({tag, " Bout held"}, {63'd0, Bout}, {63'd0, exp_bout});
    repeat (2) @(negedge clk);
    check({tag, " idle no requeue"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int saw_done;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle after reset");

    run_op("5-3", 64'd5, 64'd3, 1'b0, 1'b1, 64'd2, 1'b0, 1'b0);
    run_op("0-1", 64'd0, 64'd1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_op("slice borrow", 64'h0000_0001_0000_0000, 64'd1, 1'b0, 1'b0,
           64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
    run_op("all ones bin", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_op("signed ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
           1'b0, 64'h0246_8ACF_1357_9BCE, 1'b0, 1'b0);

    // Abort: reset during the 4th CALC cycle with start held high.
    @(negedge clk);
    A = 64'd100; B = 64'd1; Bin = 1'b0; start = 1'b1;
    @(posedge clk);          // accepting edge; CALC cycle 1 follows
    repeat (3) @(posedge clk);  // now in CALC cycle 4
    @(negedge clk);
    check("abort busy before reset", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort reset");
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("abort no done", 64'(saw_done), 64'd0);
    check("abort diff zero", diff, 64'd0);

    run_op("10-4 after reset", 64'd10, 64'd4, 1'b0, 1'b0, 64'd6, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Overall time guard so the bench always terminates.
  initial begin
    #50000;
    $display("FAIL timeout: got simulation still running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_subtractor_64.md
SEQ_SUBTRACTOR_64 -- requirements
Module: seq_subtractor_64

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1, rising-edge clock for all state.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 Port A, input, 64, minuend; sampled on the start-accepting edge.
REQ-006 Port B, input, 64, subtrahend; sampled on the start-accepting edge.
REQ-007 Port Bin, input, 1, borrow-in; sampled on the start-accepting edge.
REQ-008 Port diff, output, 64, registered result (A - B - Bin) mod 2^64.
REQ-009 Port Bout, output, 1, registered borrow-out: 1 iff unsigned A < B + Bin.
REQ-010 Port busy, output, 1, high while in CALC.
REQ-011 Port done, output, 1, one-cycle pulse marking diff/Bout valid.
REQ-012 Port V, output, 1, signed-overflow flag; present only under the configuration macro.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE, with IDLE entered from reset.
REQ-014 IDLE with start=1 at a rising edge: latch A, B and Bin; clear the slice counter to 0; load the borrow register from Bin; go to CALC.
REQ-015 CALC: each edge processes one 8-bit slice k (bits 8k+7:8k) as A_k - B_k - borrow, writes diff slice k, updates borrow and increments k.
REQ-016 CALC SHALL process slices in order k=0..7, least significant first, taking exactly 8 edges.
REQ-017 The edge that processes slice 7 SHALL also load Bout from the final borrow and move to DONE.
REQ-018 done SHALL be 1 for exactly the one cycle spent in DONE; DONE goes to IDLE on the next edge unconditionally.
REQ-019 Latency: done SHALL rise at the 8th rising edge after the start-accepting edge.
REQ-020 start SHALL be ignored in CALC and DONE, with no queuing.
REQ-021 Changes on A, B and Bin after acceptance SHALL have no effect on the operation in flight.
REQ-022 diff and Bout SHALL hold their last values in IDLE until the next accepted start.
REQ-023 diff SHALL be updated slice by slice during CALC and is valid only when done=1 or afterwards in IDLE.
REQ-024 busy SHALL be 1 exactly in CALC.
REQ-025 The 64-bit wrap-around SHALL be natural: no saturation, and borrow beyond bit 63 appears only on Bout.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, diff=0, Bout=0, busy=0, done=0, V=0, slice counter=0 and borrow register=0.
REQ-027 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start after release SHALL behave normally.

Configuration
REQ-028 Macro SEQ_SUB_OVERFLOW_EN defined: port V exists and is registered with Bout.
REQ-029 With the macro defined, V = (A[63] != B[63]) && (diff[63] != A[63]), using the latched operands.
REQ-030 Macro SEQ_SUB_OVERFLOW_EN undefined: port V and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 A=5, B=3, Bin=0, start pulse -> done exactly 8 edges later, diff=2, Bout=0, busy high for 8 cycles.
REQ-032 A=0, B=1, Bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, Bout=1.
REQ-033 A=0x0000_0001_0000_0000, B=1, Bin=0 -> diff=0x0000_0000_FFFF_FFFF, Bout=0 (borrow crosses slices 0-4).
REQ-034 A=B=0xFFFF_FFFF_FFFF_FFFF, Bin=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, Bout=1; with the macro defined, V=0.
REQ-035 A=0x8000_0000_0000_0000, B=1, Bin=0 -> diff=0x7FFF_FFFF_FFFF_FFFF, Bout=0; with the macro defined, V=1.
REQ-036 rst_n pulsed low during the 4th CALC cycle, with a second start held high during CALC -> no done pulse, all outputs 0; after release, A=10, B=4 -> diff=6 at 8 edges.
